// File: rtl/vending_change_dispenser.sv
// vending_change_dispenser: vends a can against accepted credit, then pays change
// one coin at a time through an acknowledge handshake with the nickel/dime hoppers.
module vending_change_dispenser #(
  parameter int PRICE       = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       credit_valid,
  input  logic [4:0] credit,
  output logic       credit_ready,
  output logic       can,
  output logic [1:0] coin_out,
  output logic       coin_valid,
  input  logic       coin_ack,
  input  logic       nickel_empty,
  input  logic       dime_empty,
  output logic       busy,
  output logic       change_error
);
  typedef enum logic [1:0] {IDLE, VEND, CHANGE, WAIT_ACK} state_t;
  localparam logic [4:0] PRICE_U = 5'(PRICE);
  localparam logic [4:0] LAST    = 5'(ACK_TIMEOUT - 1);
  state_t     state;
  logic [4:0] balance;
  logic [4:0] count;
  logic       accept;
  logic       paid;
  logic       use_dime;
  logic       use_nickel;
  assign accept       = credit_valid && credit_ready;
  assign paid         = credit >= PRICE_U;
  assign use_dime     = balance >= 5'd2 && !dime_empty;
  assign use_nickel   = !nickel_empty;
  assign credit_ready = state == IDLE;
  assign busy         = state != IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      balance      <= '0;
      count        <= '0;
      can          <= 1'b0;
      coin_out     <= 2'b00;
      coin_valid   <= 1'b0;
      change_error <= 1'b0;
    end else begin
      can <= 1'b0;
      case (state)
        IDLE:
          if (accept && credit != 5'd0) begin
            change_error <= 1'b0;
            balance      <= paid ? credit - PRICE_U : credit;
            can          <= paid;
            state        <= paid ? VEND : CHANGE;
          end
        VEND:
          state <= CHANGE;
        CHANGE:
          if (balance == 5'd0)
            state <= IDLE;
          else if (use_dime || use_nickel) begin
            coin_out   <= use_dime ? 2'b10 : 2'b01;
            coin_valid <= 1'b1;
            count      <= '0;
            state      <= WAIT_ACK;
          end else begin
            change_error <= 1'b1;
            balance      <= '0;
            state        <= IDLE;
          end
        WAIT_ACK:
          // an ack arriving in the final timeout cycle still counts as paid
          if (coin_ack) begin
            balance    <= balance - (coin_out == 2'b10 ? 5'd2 : 5'd1);
            coin_out   <= 2'b00;
            coin_valid <= 1'b0;
            state      <= CHANGE;
          end else if (count == LAST) begin
            coin_out     <= 2'b00;
            coin_valid   <= 1'b0;
            change_error <= 1'b1;
            balance      <= '0;
            state        <= IDLE;
          end else
            count <= count + 5'd1;
      endcase
    end
  a_no_code3: assert property (@(posedge clk) disable iff (!reset_n) coin_out != 2'b11);
  a_code_valid: assert property (@(posedge clk) disable iff (!reset_n) coin_valid == (coin_out != 2'b00));
endmodule

// File: doc/vending_change_dispenser.md
VENDING_CHANGE_DISPENSER -- requirements
Module: vending_change_dispenser

Interface
REQ-001 Parameter PRICE, default 3, item price in 5-cent units (15c).
REQ-002 Parameter ACK_TIMEOUT, default 15, maximum cycles to wait for coin_ack per coin.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock, single clock domain.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 credit_valid  input  1  credit strobe from the coin-accept FSM.
REQ-007 credit  input  5  accumulated credit in 5-cent units (0..31).
REQ-008 credit_ready  output  1  high only in IDLE; credit accepted on credit_valid && credit_ready.
REQ-009 can  output  1  one-cycle dispense-can pulse.
REQ-010 coin_out  output  2  change coin code: 00 none, 01 nickel, 10 dime; 11 never driven.
REQ-011 coin_valid  output  1  coin_out holds a coin awaiting hopper acknowledge.
REQ-012 coin_ack  input  1  hopper has ejected the presented coin.
REQ-013 nickel_empty  input  1  nickel hopper empty.
REQ-014 dime_empty  input  1  dime hopper empty.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 change_error  output  1  sticky: change could not be fully paid.

Function
REQ-017 States SHALL be IDLE, VEND, CHANGE and WAIT_ACK, with a 5-bit balance register and a 5-bit timeout counter.
REQ-018 IDLE: on an accepted credit equal to 0, stay IDLE and do not change change_error.
REQ-019 IDLE: on an accepted credit of at least PRICE, load balance = credit - PRICE, clear change_error, and go to VEND.
REQ-020 IDLE: on an accepted nonzero credit below PRICE (refund), load balance = credit, clear change_error, and go to CHANGE; no can is dispensed.
REQ-021 VEND: assert can for exactly one cycle, then go to CHANGE.
REQ-022 CHANGE, balance == 0: go to IDLE.
REQ-023 CHANGE, coin selection: choose a dime if balance >= 2 and dime_empty == 0; otherwise a nickel if nickel_empty == 0; hopper flags are sampled only in CHANGE.
REQ-024 CHANGE, no coin selectable: set change_error, discard balance, and go to IDLE.
REQ-025 CHANGE, coin selected: register coin_out, set coin_valid = 1, clear the timeout counter, and go to WAIT_ACK.
REQ-026 WAIT_ACK: coin_out and coin_valid SHALL stay stable until the coin is acknowledged or the wait times out.
REQ-027 WAIT_ACK, coin_ack == 1: decrement balance by the coin value (nickel 1, dime 2), drop coin_valid, and return to CHANGE; coin_valid is therefore low for at least one cycle between coins.
REQ-028 WAIT_ACK, no coin_ack: increment the counter; when it reaches ACK_TIMEOUT, drop coin_valid, set change_error, discard balance, and go to IDLE.
REQ-029 If coin_ack arrives in the timeout cycle, the ack SHALL win.
REQ-030 coin_ack while coin_valid == 0 SHALL be ignored.
REQ-031 credit_valid while busy SHALL be ignored and not queued.
REQ-032 Timing SHALL be: accept at edge T, can high in cycle T+1, CHANGE in T+2, first coin_valid in T+3.
REQ-033 The balance SHALL never underflow, because a dime is issued only when balance >= 2.

Reset
REQ-034 While reset_n = 0, asynchronously: state = IDLE, balance = 0, counter = 0, can = 0, coin_out = 00, coin_valid = 0, change_error = 0, busy = 0; credit_ready = 1.
REQ-035 Reset asserted mid-VEND, mid-CHANGE or mid-WAIT_ACK SHALL abort immediately with the REQ-034 values; the pending coin is dropped.

Verification
REQ-036 credit = 3 -> can high 1 cycle at T+1, no coin_valid, busy low by T+3.
REQ-037 credit = 6, immediate acks -> can pulse, then coin_out 10 (dime), then 01 (nickel), change_error = 0.
REQ-038 credit = 2 -> no can, one dime refunded; credit = 1 with nickel_empty = 1 -> change_error = 1, no coin.
REQ-039 credit = 5, dime_empty = 1 -> can pulse, then two nickels (01, 01).
REQ-040 credit = 4, coin_ack held 0 -> coin_valid high 15 cycles then low, change_error = 1, IDLE; coin_ack in the 15th cycle -> accepted, no error.
REQ-041 reset_n pulsed low in WAIT_ACK -> coin_valid = 0 without a clock edge; credit_valid held during busy -> ignored.
